or_combine_force: RTL and testbench

//  Parametrised multi-source OR combiner with a built-in, timed bit-level force/release.

---
 rtl/or_force_pkg.sv | 15 +
 rtl/force_timer.sv | 38 +++
 rtl/or_combine_force.sv | 117 +++++++++++
 tb/tb_or_combine_force.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/or_force_pkg.sv
// Shared types and helpers for the OR combiner with timed force/release.
package or_force_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TIMED = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Low bit index of source s inside a packed NUM_SRC*w source bus.
  function automatic int unsigned src_slice(input int unsigned s, input int unsigned w);
    return s * w;
  endfunction

endpackage

// File: rtl/force_timer.sv
// Load/decrement duration counter; last_o flags the final forced cycle (cnt==1).
module force_timer
  import or_force_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counting stops at 1 so the value never wraps through zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q > CNT_W'(1))) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/or_combine_force.sv
// Wired-OR combiner of NUM_SRC sources onto one net, with a per-bit force that
// either lasts a programmed number of cycles or holds until released.
module or_combine_force
  import or_force_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_i,
  input  logic [NUM_SRC-1:0]       src_en_i,
  input  logic                     force_req_i,
  output logic                     force_rdy_o,
  input  logic [WIDTH-1:0]         force_bits_i,
  input  logic [WIDTH-1:0]         force_val_i,
  input  logic [CNT_W-1:0]         force_cycles_i,
  input  logic                     release_i,
  output logic                     force_busy_o,
  output logic [WIDTH-1:0]         comb_o,
  output logic [WIDTH-1:0]         forced_o,
  output logic                     chg_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bits_q, bits_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] comb_q, comb_d;
  logic [WIDTH-1:0] forced_q, forced_d;
  logic             chg_q, chg_d;

  logic [WIDTH-1:0] masked [NUM_SRC];
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] act_mask;
  logic             accept;
  logic             timer_last;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign masked[g] = src_en_i[g] ? src_i[src_slice(g, WIDTH) +: WIDTH] : '0;
  end

  always_comb begin
    raw = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      raw = raw | masked[s];
    end
  end

  assign accept = force_req_i && (state_q == IDLE);

  force_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept && (force_cycles_i != '0)),
    .load_val_i(force_cycles_i),
    .dec_i     (state_q == TIMED),
    .last_o    (timer_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Release takes priority over expiry; both simply return to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (force_req_i) state_d = (force_cycles_i == '0) ? HOLD : TIMED;
      TIMED:   if (release_i || timer_last) state_d = IDLE;
      HOLD:    if (release_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    force_rdy_o  = (state_q == IDLE);
    force_busy_o = (state_q != IDLE);
  end

  assign act_mask = (state_q != IDLE) ? bits_q : '0;

  always_comb begin
    bits_d   = accept ? force_bits_i : bits_q;
    val_d    = accept ? force_val_i : val_q;
    comb_d   = (raw & ~act_mask) | (val_q & act_mask);
    forced_d = act_mask;
    chg_d    = (comb_d != comb_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q   <= '0;
      val_q    <= '0;
      comb_q   <= '0;
      forced_q <= '0;
      chg_q    <= 1'b0;
    end else begin
      bits_q   <= bits_d;
      val_q    <= val_d;
      comb_q   <= comb_d;
      forced_q <= forced_d;
      chg_q    <= chg_d;
    end
  end

  assign comb_o   = comb_q;
  assign forced_o = forced_q;
  assign chg_o    = chg_q;

endmodule

// File: tb/tb_or_combine_force.sv
// Scoreboard bench for or_combine_force: stimulus pushes expected outputs from a
// session-level model, an independent monitor pops and compares after each edge.
module tb_or_combine_force;

  localparam int unsigned N = 2;
  localparam int unsigned W = 8;
  localparam int unsigned C = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] src_i = '0;
  logic [N-1:0]   src_en_i = '0;
  logic           force_req_i = 1'b0;
  logic           force_rdy_o;
  logic [W-1:0]   force_bits_i = '0;
  logic [W-1:0]   force_val_i = '0;
  logic [C-1:0]   force_cycles_i = '0;
  logic           release_i = 1'b0;
  logic           force_busy_o;
  logic [W-1:0]   comb_o;
  logic [W-1:0]   forced_o;
  logic           chg_o;

  or_combine_force #(
    .NUM_SRC(N),
    .WIDTH  (W),
    .CNT_W  (C)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_i         (src_i),
    .src_en_i      (src_en_i),
    .force_req_i   (force_req_i),
    .force_rdy_o   (force_rdy_o),
    .force_bits_i  (force_bits_i),
    .force_val_i   (force_val_i),
    .force_cycles_i(force_cycles_i),
    .release_i     (release_i),
    .force_busy_o  (force_busy_o),
    .comb_o        (comb_o),
    .forced_o      (forced_o),
    .chg_o         (chg_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] comb;
    logic [W-1:0] forced;
    logic         chg;
    logic         rdy;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Session-level reference: a force session covers a number of edges, or is open-ended.
  bit           m_active;
  bit           m_hold;
  int           m_rem;
  logic [W-1:0] m_mask;
  logic [W-1:0] m_val;
  logic [W-1:0] m_prev;

  task automatic model_reset();
    m_active = 0;
    m_hold   = 0;
    m_rem    = 0;
    m_mask   = '0;
    m_val    = '0;
    m_prev   = '0;
  endtask

  // Called positioned at a falling edge; drives one cycle and returns at the next falling edge.
  task automatic step(input logic [N*W-1:0] src, input logic [N-1:0] en, input logic req,
                      input logic [W-1:0] bits, input logic [W-1:0] val,
                      input logic [C-1:0] cyc, input logic rel);
    exp_t         e;
    logic [W-1:0] r;
    logic [W-1:0] s;
    src_i = src; src_en_i = en; force_req_i = req; force_bits_i = bits;
    force_val_i = val; force_cycles_i = cyc; release_i = rel;
    r = '0;
    for (int k = 0; k < int'(N); k++) begin
      s = src[k*W +: W];
      if (en[k]) r = r | s;
    end
    e.comb   = m_active ? ((r & ~m_mask) | (m_val & m_mask)) : r;
    e.forced = m_active ? m_mask : '0;
    e.chg    = (e.comb != m_prev);
    m_prev   = e.comb;
    if (m_active) begin
      if (rel) m_active = 0;
      else if (!m_hold) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_active = 0;
      end
    end else if (req) begin
      m_active = 1;
      m_mask   = bits;
      m_val    = val;
      m_hold   = (cyc == '0);
      m_rem    = int'(cyc);
    end
    e.rdy = !m_active;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input logic [N*W-1:0] src, input logic [N-1:0] en, input int n);
    for (int k = 0; k < n; k++) step(src, en, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // Monitor: outputs checked #1 after every rising edge, and right after reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        checks++;
        if (comb_o !== '0 || forced_o !== '0 || chg_o !== 1'b0 ||
            force_rdy_o !== 1'b1 || force_busy_o !== 1'b0) begin
          errors++;
          $display("FAIL reset_state: comb=%h forced=%h chg=%b rdy=%b busy=%b, want 00 00 0 1 0",
                   comb_o, forced_o, chg_o, force_rdy_o, force_busy_o);
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (comb_o !== e.comb || forced_o !== e.forced || chg_o !== e.chg ||
            force_rdy_o !== e.rdy || force_busy_o !== !e.rdy) begin
          errors++;
          $display("FAIL edge_out t=%0t: comb=%h forced=%h chg=%b rdy=%b busy=%b, want %h %h %b %b %b",
                   $time, comb_o, forced_o, chg_o, force_rdy_o, force_busy_o,
                   e.comb, e.forced, e.chg, e.rdy, !e.rdy);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] rs;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Wired-OR and source enables
    idle(16'hF00F, 2'b11, 3);
    idle(16'hF00F, 2'b01, 2);
    idle(16'hF00F, 2'b10, 2);
    idle(16'hF00F, 2'b00, 2);

    // Timed force of 3 edges, with a second request ignored while busy
    step(16'h0000, 2'b11, 1'b1, 8'h03, 8'h02, 8'd3, 1'b0);
    step(16'h0000, 2'b11, 1'b1, 8'hFF, 8'hFF, 8'd5, 1'b0);
    idle(16'h0000, 2'b11, 5);

    // Hold until release
    step(16'h3C00, 2'b11, 1'b1, 8'hFF, 8'hA5, 8'd0, 1'b0);
    idle(16'h3C00, 2'b11, 6);
    step(16'h3C00, 2'b11, 1'b0, '0, '0, '0, 1'b1);
    idle(16'h3C00, 2'b11, 2);

    // Release on the final timed cycle: single exit, no re-force
    step(16'h0101, 2'b11, 1'b1, 8'hF0, 8'h50, 8'd3, 1'b0);
    idle(16'h0101, 2'b11, 2);
    step(16'h0101, 2'b11, 1'b0, '0, '0, '0, 1'b1);
    idle(16'h0101, 2'b11, 3);

    // Request and release together while idle: request wins
    step(16'h0000, 2'b11, 1'b1, 8'h0F, 8'h09, 8'd2, 1'b1);
    idle(16'h0000, 2'b11, 4);

    // Zero force mask, and one-cycle timed force
    step(16'h2222, 2'b11, 1'b1, 8'h00, 8'hFF, 8'd2, 1'b0);
    idle(16'h2222, 2'b11, 3);
    step(16'h0000, 2'b11, 1'b1, 8'h80, 8'h80, 8'd1, 1'b0);
    idle(16'h0000, 2'b11, 3);

    // Maximum duration
    step(16'h0000, 2'b11, 1'b1, 8'h01, 8'h01, 8'd255, 1'b0);
    idle(16'h0000, 2'b11, 258);

    // Asynchronous reset during HOLD
    step(16'h00C3, 2'b11, 1'b1, 8'hFF, 8'h5A, 8'd0, 1'b0);
    idle(16'h00C3, 2'b11, 3);
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(16'h00C3, 2'b11, 3);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      rs = N*W'($urandom);
      if ($urandom_range(0, 3) == 0) rs = '0;
      step(rs, N'($urandom), ($urandom_range(0, 2) == 0), W'($urandom), W'($urandom),
           C'($urandom_range(0, 6)), ($urandom_range(0, 7) == 0));
    end
    idle('0, '0, 2);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
